// File: rtl/rgb_fade_pkg.sv
// rgb_fade_pkg: shared types and constants for the RGB fade sequencer.
//   state_e      - sequencer FSM states
//   COLOUR_FIRST - first non-black colour mask
//   COLOUR_LAST  - last colour mask before wrapping back to COLOUR_FIRST
package rgb_fade_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_IN,
    S_HOLD,
    S_FADE_OUT,
    S_NEXT
  } state_e;

  localparam logic [2:0] COLOUR_FIRST = 3'b001;
  localparam logic [2:0] COLOUR_LAST  = 3'b111;

  // Step through the seven non-black masks, skipping 3'b000.
  function automatic logic [2:0] colour_next(input logic [2:0] colour);
    return (colour == COLOUR_LAST) ? COLOUR_FIRST : colour + 3'd1;
  endfunction

endpackage

// File: rtl/rgb_fade_controller_if.sv
// rgb_fade_controller_if: control/status bundle of the RGB fade sequencer.
//   i_ena  - enable level (0 forces idle)
//   i_next - one-cycle request to advance early to the next colour
//   o_rgb  - registered LED drive, bit set = channel on
//   o_leds - [0] holding at full duty, [1] fading in or out
//   o_busy - sequencer not idle
// master: the button front end side; slave: the sequencer.
interface rgb_fade_controller_if;
  logic       i_ena;
  logic       i_next;
  logic [2:0] o_rgb;
  logic [1:0] o_leds;
  logic       o_busy;

  modport master (output i_ena, output i_next, input o_rgb, input o_leds, input o_busy);
  modport slave  (input i_ena, input i_next, output o_rgb, output o_leds, output o_busy);
endinterface

// File: rtl/rgb_fade_controller_pwm.sv
// pwm: single PWM generator shared by all three colour channels.
//   clk, rst_n       - clock, asynchronous active-low reset
//   i_duty           - requested duty, sampled once per period
//   o_pwm_on         - high while counter < shadowed duty
//   o_period_start   - high while the counter sits at 0
module pwm #(
  parameter int unsigned PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PWM_WIDTH-1:0] i_duty,
  output logic                 o_pwm_on,
  output logic                 o_period_start
);

  logic [PWM_WIDTH-1:0] r_cnt;
  logic [PWM_WIDTH-1:0] r_shadow;

  // Shadow duty only changes as the counter wraps, so a period never mixes two duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) begin
        r_shadow <= i_duty;
      end
    end
  end

  assign o_pwm_on       = (r_cnt < r_shadow);
  assign o_period_start = (r_cnt == '0);

endmodule

// File: rtl/rgb_fade_controller.sv
// rgb_fade_controller: steps a colour mask through the seven non-black masks while
// ramping a shared PWM duty up, holding it, and ramping it back down.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of rgb_fade_controller_if (ena/next in, rgb/leds/busy out)
module rgb_fade_controller
  import rgb_fade_pkg::*;
#(
  parameter int unsigned PWM_WIDTH  = 4,
  parameter int unsigned STEP_TICKS = 12_000,
  parameter int unsigned HOLD_STEPS = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  rgb_fade_controller_if.slave bus
);

  localparam int unsigned PRESC_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_STEPS + 1);

  localparam logic [PWM_WIDTH-1:0] DUTY_MAX   = '1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(STEP_TICKS - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(HOLD_STEPS);

  state_e               r_state, w_state_d;
  logic [PWM_WIDTH-1:0] r_duty, w_duty_d;
  logic [PRESC_W-1:0]   r_presc, w_presc_d;
  logic [HOLD_W-1:0]    r_hold, w_hold_d;
  logic [2:0]           r_colour, w_colour_d;
  logic [2:0]           r_rgb;
  logic [1:0]           r_leds;
  logic                 r_busy;
  logic                 w_tick;
  logic                 w_pwm_on;
  logic                 w_period_start;

  always_comb begin
    w_state_d  = r_state;
    w_duty_d   = r_duty;
    w_hold_d   = r_hold;
    w_colour_d = r_colour;
    w_tick     = (r_state != S_IDLE) && (r_presc == PRESC_LAST);

    // Dropping enable wins over next and tick in the same cycle.
    if (!bus.i_ena) begin
      w_state_d = S_IDLE;
      w_duty_d  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_d = S_FADE_IN;
          w_duty_d  = '0;
        end
        S_FADE_IN: begin
          if (bus.i_next) begin
            w_state_d = S_FADE_OUT;
          end else if (w_tick) begin
            if (r_duty != DUTY_MAX) w_duty_d = r_duty + 1'b1;
            if (w_duty_d == DUTY_MAX) begin
              w_state_d = S_HOLD;
              w_hold_d  = '0;
            end
          end
        end
        S_HOLD: begin
          if (bus.i_next) begin
            w_state_d = S_FADE_OUT;
          end else if (w_tick) begin
            w_hold_d = r_hold + 1'b1;
            if (w_hold_d == HOLD_LAST) w_state_d = S_FADE_OUT;
          end
        end
        S_FADE_OUT: begin
          if (w_tick) begin
            if (r_duty != '0) w_duty_d = r_duty - 1'b1;
            if (w_duty_d == '0) w_state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          w_colour_d = colour_next(r_colour);
          w_state_d  = S_FADE_IN;
        end
        default: w_state_d = S_IDLE;
      endcase
    end

    // Restart the step timer on every state change so each phase lasts whole steps.
    if ((r_state == S_IDLE) || (w_state_d != r_state) || w_tick) begin
      w_presc_d = '0;
    end else begin
      w_presc_d = r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_duty   <= '0;
      r_presc  <= '0;
      r_hold   <= '0;
      r_colour <= COLOUR_FIRST;
      r_rgb    <= '0;
      r_leds   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_duty   <= w_duty_d;
      r_presc  <= w_presc_d;
      r_hold   <= w_hold_d;
      r_colour <= w_colour_d;
      r_rgb    <= r_colour & {3{w_pwm_on}};
      // Status decodes the next state so it lines up with r_state.
      r_leds   <= {(w_state_d == S_FADE_IN) || (w_state_d == S_FADE_OUT),
                   (w_state_d == S_HOLD)};
      r_busy   <= (w_state_d != S_IDLE);
    end
  end

  pwm #(
    .PWM_WIDTH(PWM_WIDTH)
  ) u_pwm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_duty        (r_duty),
    .o_pwm_on      (w_pwm_on),
    .o_period_start(w_period_start)
  );

  assign bus.o_rgb  = r_rgb;
  assign bus.o_leds = r_leds;
  assign bus.o_busy = r_busy;

endmodule

// File: tb/tb_rgb_fade_controller.sv
// Bench for rgb_fade_controller with PWM_WIDTH=4, STEP_TICKS=2, HOLD_STEPS=3.
module tb_rgb_fade_controller;

  localparam int ST = 2;
  localparam int HS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rgb_fade_controller_if bus ();

  rgb_fade_controller #(
    .PWM_WIDTH (4),
    .STEP_TICKS(ST),
    .HOLD_STEPS(HS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: phase 0 idle, 1 fade in, 2 hold, 3 fade out, 4 next.
  // m_left counts clocks remaining until the current step completes.
  int m_phase, m_duty, m_colour, m_left, m_held, m_cycle, m_shadow, m_rgb;

  task automatic model_reset();
    m_phase = 0; m_duty = 0; m_colour = 1; m_left = ST;
    m_held = 0; m_cycle = 0; m_shadow = 0; m_rgb = 0;
  endtask

  task automatic model_step(input logic e, input logic n);
    int cnt;
    cnt = m_cycle % 16;
    m_rgb = (cnt < m_shadow) ? m_colour : 0;
    if (cnt == 15) m_shadow = m_duty;
    m_cycle++;
    if (!e) begin
      m_phase = 0; m_duty = 0; m_left = ST;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_left = ST; end
        1: if (n) begin m_phase = 3; m_left = ST; end
           else begin
             m_left--;
             if (m_left == 0) begin
               m_left = ST;
               if (m_duty < 15) m_duty++;
               if (m_duty == 15) begin m_phase = 2; m_held = 0; end
             end
           end
        2: if (n) begin m_phase = 3; m_left = ST; end
           else begin
             m_left--;
             if (m_left == 0) begin
               m_left = ST;
               m_held++;
               if (m_held == HS) m_phase = 3;
             end
           end
        3: begin
             m_left--;
             if (m_left == 0) begin
               m_left = ST;
               if (m_duty > 0) m_duty--;
               if (m_duty == 0) m_phase = 4;
             end
           end
        default: begin
             m_colour = (m_colour == 7) ? 1 : m_colour + 1;
             m_phase = 1; m_left = ST;
           end
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(bus.i_ena, bus.i_next);
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rgb", int'(bus.o_rgb), m_rgb);
        chk("busy", int'(bus.o_busy), int'(m_phase != 0));
        chk("leds", int'(bus.o_leds), {30'd0, (m_phase == 1) || (m_phase == 3), m_phase == 2});
        chk("colour", int'(dut.r_colour), m_colour);
        chk("duty", int'(dut.r_duty), m_duty);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] leds_a[67];
  logic       busy_a[67];
  logic [2:0] rgb_a[67];
  int         exp_col[6];

  initial begin
    int n_in, n_hold, n_nxt, first_hold, first_nxt, on0, k;
    bus.i_ena = 1'b1;
    bus.i_next = 1'b0;
    exp_col = '{3, 4, 5, 6, 7, 1};

    // 1. Reset state with ena already high.
    repeat (2) @(negedge clk);
    chk("rst_rgb", int'(bus.o_rgb), 0);
    chk("rst_leds", int'(bus.o_leds), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    rst_n = 1'b1;

    // 1/2. Record one full colour cycle.
    for (int i = 0; i < 67; i++) begin
      @(negedge clk);
      leds_a[i] = bus.o_leds;
      busy_a[i] = bus.o_busy;
      rgb_a[i]  = bus.o_rgb;
      if (i == 0) chk("first_busy", int'(bus.o_busy), 1);
      if (i == 1) chk("duty_before_tick", int'(dut.r_duty), 0);
      if (i == 2) chk("first_increment", int'(dut.r_duty), 1);
    end
    n_in = 0; n_hold = 0; n_nxt = 0; first_hold = -1; first_nxt = -1; on0 = 0;
    for (int i = 0; i < 67; i++) begin
      if (leds_a[i] == 2'b10) n_in++;
      if (leds_a[i] == 2'b01) begin
        n_hold++;
        if (first_hold < 0) first_hold = i;
      end
      if (busy_a[i] && leds_a[i] == 2'b00) begin
        n_nxt++;
        if (first_nxt < 0) first_nxt = i;
      end
      if (i >= 32 && i <= 47 && rgb_a[i][0]) on0++;
    end
    chk("fade_clocks", n_in, 60);
    chk("hold_clocks", n_hold, 6);
    chk("next_clocks", n_nxt, 1);
    chk("hold_start", first_hold, 30);
    chk("next_start", first_nxt, 66);
    chk("full_duty_on_of_16", on0, 15);
    @(negedge clk);
    chk("colour_after_cycle1", int'(dut.r_colour), 2);

    // 3. Six more cycles: colour walks to 111 then wraps to 001.
    for (int c = 0; c < 6; c++) begin
      repeat (67) @(negedge clk);
      chk("colour_walk", int'(dut.r_colour), exp_col[c]);
    end

    // 4. next during fade-in at duty 6, then an ignored next in fade-out.
    k = 0;
    while (!(m_phase == 1 && m_duty == 6) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_duty6", int'(k < 200), 1);
    bus.i_next = 1'b1;
    @(negedge clk);
    bus.i_next = 1'b0;
    chk("next_duty_kept", int'(dut.r_duty), 6);
    chk("next_fading", int'(bus.o_leds), 2);
    repeat (3) @(negedge clk);
    bus.i_next = 1'b1;
    @(negedge clk);
    bus.i_next = 1'b0;
    repeat (8) @(negedge clk);
    chk("fadeout12_leds", int'(bus.o_leds), 0);
    chk("fadeout12_busy", int'(bus.o_busy), 1);
    chk("fadeout12_duty", int'(dut.r_duty), 0);
    @(negedge clk);
    chk("colour_after_next", int'(dut.r_colour), 2);

    // 5. ena low together with next while holding.
    k = 0;
    while (m_phase != 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_hold", int'(k < 200), 1);
    bus.i_ena = 1'b0;
    bus.i_next = 1'b1;
    @(negedge clk);
    bus.i_next = 1'b0;
    chk("disable_busy", int'(bus.o_busy), 0);
    chk("disable_leds", int'(bus.o_leds), 0);
    repeat (17) @(negedge clk);
    chk("disable_rgb_dark", int'(bus.o_rgb), 0);
    bus.i_ena = 1'b1;
    @(negedge clk);
    chk("reenable_busy", int'(bus.o_busy), 1);
    chk("reenable_colour", int'(dut.r_colour), 2);

    // 6. Asynchronous reset mid fade-out while an LED is lit.
    k = 0;
    while (!(m_phase == 3 && bus.o_rgb != 3'b000) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reach_fadeout_lit", int'(k < 300), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rgb", int'(bus.o_rgb), 0);
    chk("async_leds", int'(bus.o_leds), 0);
    chk("async_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    chk("async_colour", int'(dut.r_colour), 1);
    chk("async_duty", int'(dut.r_duty), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_fade_controller.md
# rgb_fade_controller

Sequencer for the board's RGB LED. It steps a colour index through the seven non-black RGB masks and ramps a shared PWM duty value up, holds it, and ramps it back down. The three `rgb` outputs are gated from one PWM instance. It sits between the button front end in `main` and the `rgb` pins, and replaces direct duty wiring with a scheduled fade.

## Interface
- `PWM_WIDTH`, 4: duty and PWM counter width; period = 2^PWM_WIDTH clocks.
- `STEP_TICKS`, 12_000: clocks per fade step (prescaler), ≥1.
- `HOLD_STEPS`, 64: fade steps spent at full duty, ≥1.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ena`  in  1  level, already synchronized; 0 forces IDLE.
- `next`  in  1  one-cycle pulse; request early advance to the next colour.
- `rgb`  out  3  registered LED drive, bit set = channel on.
- `leds`  out  2  `[0]`=in HOLD, `[1]`=fading (FADE_IN or FADE_OUT).
- `busy`  out  1  state ≠ IDLE.

## Operation
- Reset values: state IDLE, colour=3'b001, duty=0, shadow duty=0, prescaler=0, hold count=0, PWM counter=0. `rgb`=0, `leds`=0, `busy`=0.
- Prescaler counts 0..STEP_TICKS-1 while not IDLE. `tick` is asserted on wrap. In IDLE it is held at 0.
- FSM states and transitions:
  - IDLE: duty forced to 0. Goes to FADE_IN when `ena`=1.
  - FADE_IN: on each `tick`, duty+1. When a tick makes duty=2^W-1, go to HOLD and clear hold count.
  - HOLD: on each `tick`, hold count+1. When it reaches HOLD_STEPS, go to FADE_OUT.
  - FADE_OUT: on each `tick`, duty-1. When a tick makes duty=0, go to NEXT.
  - NEXT (one cycle): colour+1, wrapping 3'b111 to 3'b001 (never 0). Then FADE_IN.
- Duty saturates at 0 and 2^W-1. It never wraps.
- `next`=1 in FADE_IN or HOLD: go to FADE_OUT on the following cycle, duty unchanged. In FADE_OUT, NEXT or IDLE it is ignored.
- `ena`=0 in any state: go to IDLE next cycle and set duty=0. Colour is retained. This has priority over `next` and over `tick` in the same cycle.
- Shadow duty loads from duty only when the PWM counter wraps to 0. Each PWM period therefore uses one duty value, with no glitch mid-period.
- PWM: the counter free-runs from reset, including in IDLE. `pwm_on` = (counter < shadow duty). `rgb` = colour & {3{pwm_on}}, registered.
- Duty 0 gives `rgb` constantly 0. Duty 2^W-1 gives each enabled channel on for 2^W-1 of every 2^W clocks.

## Timing
- `rgb` lags `pwm_on` by one register: one clock after the counter/shadow comparison.
- A duty change reaches `rgb` at the next PWM period start, plus one clock.
- `busy` and `leds` are registered decodes of state and update in the cycle after the transition.
- `ena` rising to first `tick`: STEP_TICKS clocks after entering FADE_IN.
- Full fade-in: (2^W-1)·STEP_TICKS clocks. Hold: HOLD_STEPS·STEP_TICKS. Fade-out: same as fade-in. NEXT: 1 clock.
- Reset mid-operation: all registers return to reset values asynchronously. Operation restarts from IDLE with colour 3'b001.

## Structure
- Package `rgb_fade_pkg` holds:
  - the FSM state enum (`S_IDLE`, `S_FADE_IN`, `S_HOLD`, `S_FADE_OUT`, `S_NEXT`);
  - `COLOUR_FIRST` = 3'b001;
  - `COLOUR_LAST` = 3'b111.
- One sub-module, `pwm`, parameterized by `PWM_WIDTH`. It contains the free-running counter, the shadow duty load and the `<` compare, and outputs `pwm_on` and `period_start`.
- The FSM, prescaler, hold counter and colour register live in `rgb_fade_controller`.

## Test plan
Bench setting for all scenarios: `PWM_WIDTH`=4, `STEP_TICKS`=2, `HOLD_STEPS`=3.
1. Reset with `rst_n`=0, `ena`=1 → `rgb`=0, `leds`=0, `busy`=0. Release → `busy`=1 one cycle later, and the first duty increment occurs 2 clocks after FADE_IN entry.
2. Full cycle with `ena`=1 and no `next` → FADE_IN for 30 clocks to duty 15, HOLD for 6 clocks, FADE_OUT for 30 clocks, one NEXT clock. The colour changes 3'b001 → 3'b010. In HOLD, `rgb[0]` is high for 15 of each 16 clocks.
3. Colour wrap: run 7 full cycles → colour sequence 001, 010, 011, …, 111, 001. `rgb` is never nonzero on any channel outside the current mask.
4. `next` pulse during FADE_IN at duty 6 → FADE_OUT the next cycle. Duty falls 6→0 over 12 clocks, then the colour advances. A `next` pulse during FADE_OUT has no effect.
5. `ena` dropped in the same cycle as `next` while in HOLD → IDLE and `busy`=0 the next cycle. `rgb`=0 from the following PWM period start +1 onward. Colour is unchanged when `ena` returns.
6. Async reset asserted mid-FADE_OUT, between clock edges → `rgb`, `leds` and `busy` go to 0 immediately, without waiting for a clock edge. After release, colour=3'b001 and duty=0.
